// File: rtl/fifo_block_packer.sv
// fifo_block_packer
//
// Read-side consumer for the byte FIFO feeding the cipher core. Words are
// popped one per cycle, packed MSB-first into a BLOCK_BYTES-word block and
// offered to the cipher core over a valid/ready handshake. A flush request
// emits the current partial block, padded with PAD_BYTE, together with the
// number of valid words it carries.
//
// Ports:
//   i_clk           rising-edge clock
//   i_rst_n         asynchronous active-low reset
//   o_fifo_rd_en    pop request to the FIFO (combinational)
//   i_fifo_rd_data  FIFO read data, valid the cycle after o_fifo_rd_en
//   i_fifo_empty    FIFO empty flag
//   i_flush         single-cycle request to emit the current partial block
//   o_blk_data      packed block, first popped word in the top WIDTH bits
//   o_blk_nbytes    number of valid words in o_blk_data
//   o_blk_valid     block available
//   i_blk_ready     cipher core accepts the block
//   o_busy          words held, a read in flight, or a block pending

module fifo_block_packer #(
  parameter int               WIDTH       = 8,
  parameter int               BLOCK_BYTES = 16,
  parameter logic [WIDTH-1:0] PAD_BYTE    = 8'h00,
  localparam int              OUT_W       = WIDTH * BLOCK_BYTES,
  localparam int              CNT_W       = $clog2(BLOCK_BYTES) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_fifo_rd_en,
  input  logic [WIDTH-1:0] i_fifo_rd_data,
  input  logic             i_fifo_empty,
  input  logic             i_flush,
  output logic [OUT_W-1:0] o_blk_data,
  output logic [CNT_W-1:0] o_blk_nbytes,
  output logic             o_blk_valid,
  input  logic             i_blk_ready,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BYTES - 1);

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;       // words captured into the block
  logic [CNT_W-1:0] issued;      // pops requested for the block
  logic             rd_pend;     // a pop was issued last cycle, data arrives now
  logic             flush_pend;  // latched flush request, waiting to be served

  // Pops are only requested while filling, with room left in the block and
  // no flush waiting; the reset term keeps the FIFO untouched during reset.
  assign o_fifo_rd_en = i_rst_n && (state == ST_FILL) && !i_fifo_empty &&
                        (issued < FULL_CNT) && !flush_pend;

  assign o_busy = (count != '0) || rd_pend || o_blk_valid;

  // Main packing state machine. The last word of a full block is captured on
  // the same edge that raises o_blk_valid, which gives BLOCK_BYTES+2 cycles
  // per block with ready tied high. A flush is served only once no read is in
  // flight, so a word already requested still lands in the flushed block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_FILL;
      count        <= '0;
      issued       <= '0;
      rd_pend      <= 1'b0;
      flush_pend   <= 1'b0;
      o_blk_data   <= '0;
      o_blk_nbytes <= '0;
      o_blk_valid  <= 1'b0;
    end else begin
      rd_pend    <= o_fifo_rd_en;
      flush_pend <= flush_pend | i_flush;
      if (o_fifo_rd_en) begin
        issued <= issued + 1'b1;
      end

      case (state)
        ST_FILL: begin
          if (rd_pend) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
              if (count == CNT_W'(i)) begin
                o_blk_data[OUT_W-1-i*WIDTH -: WIDTH] <= i_fifo_rd_data;
              end
            end
            count <= count + 1'b1;
            // A flush seen alongside the final word stays pending for the
            // next fill; the full block goes out first.
            if (count == LAST_CNT) begin
              state        <= ST_VALID;
              o_blk_valid  <= 1'b1;
              o_blk_nbytes <= FULL_CNT;
            end
          end else if (flush_pend) begin
            // A fresh i_flush on the serving cycle is kept for the next fill.
            flush_pend <= i_flush;
            if (count != '0) begin
              for (int i = 0; i < BLOCK_BYTES; i++) begin
                if (CNT_W'(i) >= count) begin
                  o_blk_data[OUT_W-1-i*WIDTH -: WIDTH] <= PAD_BYTE;
                end
              end
              state        <= ST_VALID;
              o_blk_valid  <= 1'b1;
              o_blk_nbytes <= count;
            end
          end
        end

        ST_VALID: begin
          if (i_blk_ready) begin
            state       <= ST_FILL;
            o_blk_valid <= 1'b0;
            count       <= '0;
            issued      <= '0;
          end
        end

        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_block_packer.sv
// tb_fifo_block_packer
//
// Self-checking bench for fifo_block_packer. A registered-read FIFO model
// feeds the design; every pushed byte is also appended to an expected byte
// stream. Each accepted block must equal the next nbytes bytes of that stream
// placed MSB-first, with the remaining words padded with zero.

module tb_fifo_block_packer;

  localparam int WIDTH = 8;
  localparam int BB    = 16;
  localparam int OUT_W = WIDTH * BB;
  localparam int CNT_W = $clog2(BB) + 1;
  localparam int MEM_D = 1024;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rd_en;
  logic [WIDTH-1:0] fifo_rd_data = '0;
  logic             fifo_empty;
  logic             flush;
  logic [OUT_W-1:0] blk_data;
  logic [CNT_W-1:0] blk_nbytes;
  logic             blk_valid;
  logic             blk_ready;
  logic             busy;

  int tests_run = 0;
  int fail_cnt  = 0;

  // FIFO model storage: written only by the stimulus, drained only by the
  // pop process, so each counter has a single owner.
  logic [7:0] fifo_mem [0:MEM_D-1];
  int         push_cnt      = 0;
  int         pop_cnt       = 0;
  int         underflow_cnt = 0;
  logic [7:0] exp_stream [$];

  // Blocks accepted by the design, recorded by the monitor.
  logic [OUT_W-1:0] obs_data [0:255];
  logic [CNT_W-1:0] obs_nb   [0:255];
  int               obs_cnt      = 0;
  int               obs_rd       = 0;
  int               valid_cycles = 0;

  assign fifo_empty = (push_cnt == pop_cnt);

  fifo_block_packer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .o_fifo_rd_en   (rd_en),
    .i_fifo_rd_data (fifo_rd_data),
    .i_fifo_empty   (fifo_empty),
    .i_flush        (flush),
    .o_blk_data     (blk_data),
    .o_blk_nbytes   (blk_nbytes),
    .o_blk_valid    (blk_valid),
    .i_blk_ready    (blk_ready),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  // FIFO read port: data registered one cycle after the pop; the FIFO shares
  // the system reset, so its contents are dropped while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      pop_cnt <= push_cnt;
    end else if (rd_en) begin
      if (pop_cnt != push_cnt) begin
        fifo_rd_data <= fifo_mem[pop_cnt % MEM_D];
        pop_cnt      <= pop_cnt + 1;
      end else begin
        underflow_cnt <= underflow_cnt + 1;
      end
    end
  end

  // Block monitor: sampled on the falling edge, a valid&&ready here means
  // the transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && blk_valid) begin
      valid_cycles <= valid_cycles + 1;
      if (blk_ready) begin
        obs_data[obs_cnt] <= blk_data;
        obs_nb[obs_cnt]   <= blk_nbytes;
        obs_cnt           <= obs_cnt + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [OUT_W-1:0] observed,
                             input logic [OUT_W-1:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifo_mem[push_cnt % MEM_D] = b;
    push_cnt++;
    exp_stream.push_back(b);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for the next accepted block and checks it against the
  // next nb bytes of the expected stream.
  task automatic expect_block(input string tag, input int nb);
    int               waited;
    logic [OUT_W-1:0] exp_d;
    waited = 0;
    while (obs_cnt == obs_rd && waited < 300) begin
      step();
      waited++;
    end
    checkOutput({tag, "_arrived"}, OUT_W'(obs_cnt != obs_rd), OUT_W'(1));
    if (obs_cnt != obs_rd) begin
      exp_d = '0;
      for (int i = 0; i < nb; i++) begin
        exp_d[OUT_W-1-8*i -: 8] = exp_stream.pop_front();
      end
      checkOutput({tag, "_nbytes"}, OUT_W'(obs_nb[obs_rd]), OUT_W'(nb));
      checkOutput({tag, "_data"}, obs_data[obs_rd], exp_d);
      obs_rd++;
    end
  endtask

  initial begin
    int               rd_hi;
    int               rd_last;
    int               first_valid;
    int               v0;
    int               w;
    int               pushed;
    logic             gap_rd;
    logic [OUT_W-1:0] held;

    rst_n     = 1'b1;
    flush     = 1'b0;
    blk_ready = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    checkOutput("rst_data",   blk_data,           '0);
    checkOutput("rst_nbytes", OUT_W'(blk_nbytes), '0);
    checkOutput("rst_valid",  OUT_W'(blk_valid),  '0);
    checkOutput("rst_busy",   OUT_W'(busy),       '0);
    checkOutput("rst_rd_en",  OUT_W'(rd_en),      '0);
    step(3);
    rst_n = 1'b1;
    step(2);

    // Full block timing with 0x00..0x0F and ready high.
    for (int i = 0; i < BB; i++) applyStimulus(8'(i));
    rd_hi = 0; rd_last = -1; first_valid = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      #1;
      if (rd_en) begin rd_hi++; rd_last = cyc; end
      if (blk_valid && first_valid < 0) first_valid = cyc;
      step();
    end
    checkOutput("full_rd_count", OUT_W'(rd_hi),       OUT_W'(16));
    checkOutput("full_rd_last",  OUT_W'(rd_last),     OUT_W'(15));
    checkOutput("full_valid_at", OUT_W'(first_valid), OUT_W'(17));
    expect_block("full", 16);
    checkOutput("full_const", obs_data[obs_rd-1], 128'h000102030405060708090A0B0C0D0E0F);

    // Backpressure: block must hold and no pops while the FIFO still has data.
    blk_ready = 1'b0;
    for (int i = 0; i < 2 * BB; i++) applyStimulus(8'($urandom));
    w = 0;
    while (!blk_valid && w < 40) begin step(); w++; end
    checkOutput("bp_valid_rise", OUT_W'(blk_valid), OUT_W'(1));
    held = blk_data;
    for (int k = 0; k < 5; k++) begin
      step();
      #1;
      checkOutput("bp_valid_hold", OUT_W'(blk_valid), OUT_W'(1));
      checkOutput("bp_data_hold",  blk_data,          held);
      checkOutput("bp_no_rd",      OUT_W'(rd_en),     OUT_W'(0));
    end
    step();
    blk_ready = 1'b1;
    step();
    checkOutput("bp_accept", OUT_W'(blk_valid), OUT_W'(0));
    expect_block("bp_first", 16);
    expect_block("bp_second", 16);

    // Partial flush after three pops.
    step();
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'hCC);
    step(6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    expect_block("partial", 3);
    checkOutput("partial_const", obs_data[obs_rd-1], 128'hAABBCC00000000000000000000000000);

    // Flush with nothing held must never produce a block.
    step(3);
    v0 = valid_cycles;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step(10);
    checkOutput("empty_flush_no_valid", OUT_W'(valid_cycles - v0), OUT_W'(0));
    checkOutput("empty_flush_idle",     OUT_W'(busy),              OUT_W'(0));
    for (int i = 0; i < BB; i++) applyStimulus(8'($urandom));
    expect_block("after_empty_flush", 16);

    // Flush on the cycle of the final read: full block first, then the
    // pending flush meets an empty fill and is dropped.
    step(2);
    for (int i = 0; i < 2 * BB; i++) applyStimulus(8'($urandom));
    step(15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    expect_block("flush_last_rd", 16);
    expect_block("flush_dropped", 16);

    // Underflow gap in the middle of a block.
    step(2);
    for (int i = 0; i < 8; i++) applyStimulus(8'($urandom));
    step(9);
    gap_rd = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      gap_rd = gap_rd | rd_en;
      step();
    end
    checkOutput("gap_no_rd", OUT_W'(gap_rd), OUT_W'(0));
    checkOutput("gap_busy",  OUT_W'(busy),   OUT_W'(1));
    for (int i = 0; i < 8; i++) applyStimulus(8'($urandom));
    expect_block("gap", 16);

    // Reset in the middle of a block discards held and in-flight words.
    step(2);
    for (int i = 0; i < BB; i++) applyStimulus(8'($urandom));
    step(5);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_data",   blk_data,           '0);
    checkOutput("mid_rst_nbytes", OUT_W'(blk_nbytes), '0);
    checkOutput("mid_rst_valid",  OUT_W'(blk_valid),  '0);
    checkOutput("mid_rst_busy",   OUT_W'(busy),       '0);
    checkOutput("mid_rst_rd_en",  OUT_W'(rd_en),      '0);
    exp_stream.delete();
    step(2);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < BB; i++) applyStimulus(8'(8'h10 + i));
    expect_block("post_rst", 16);
    checkOutput("post_rst_const", obs_data[obs_rd-1], 128'h101112131415161718191A1B1C1D1E1F);

    // Random bursts and random backpressure over 20 full blocks.
    pushed = 0;
    w = 0;
    while (pushed < 20 * BB && w < 4000) begin
      step();
      blk_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        for (int k = $urandom_range(1, 4); k > 0; k--) begin
          if (pushed < 20 * BB) begin
            applyStimulus(8'($urandom));
            pushed++;
          end
        end
      end
      w++;
    end
    step();
    blk_ready = 1'b1;
    w = 0;
    while ((obs_cnt - obs_rd) < 20 && w < 1000) begin step(); w++; end
    for (int b = 0; b < 20; b++) expect_block("rand", 16);

    // Short tail drained by a flush.
    step();
    for (int i = 0; i < 5; i++) applyStimulus(8'($urandom));
    step(10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    expect_block("tail", 5);

    step(20);
    checkOutput("no_extra_blocks", OUT_W'(obs_cnt - obs_rd),     OUT_W'(0));
    checkOutput("no_underflow",    OUT_W'(underflow_cnt),        OUT_W'(0));
    checkOutput("stream_drained",  OUT_W'(exp_stream.size()),    OUT_W'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
